// File: rtl/multiplier_iterative_8b_if.sv
// Operand/product stream bundle for the iterative multiplier.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where val=1 and rdy=1 on that stream. The producer holds its data stable
// while val=1 and rdy=0. rdy never depends combinationally on val.
interface multiplier_iterative_8b_if #(
   parameter int NBITS = 8
);

   // Operand stream (producer -> multiplier)
   logic               istream_val;
   logic               istream_rdy;
   logic [NBITS-1:0]   in0;
   logic [NBITS-1:0]   in1;

   // Product stream (multiplier -> consumer)
   logic               ostream_val;
   logic               ostream_rdy;
   logic [2*NBITS-1:0] product;

   // Environment side: drives operands and accepts products
   modport master (
      output istream_val,
      output in0,
      output in1,
      output ostream_rdy,
      input  istream_rdy,
      input  ostream_val,
      input  product
   );

   // Multiplier side
   modport slave (
      input  istream_val,
      input  in0,
      input  in1,
      input  ostream_rdy,
      output istream_rdy,
      output ostream_val,
      output product
   );

endinterface

// File: rtl/multiplier_iterative_8b.sv
// Unsigned iterative shift-and-add multiplier, NBITS x NBITS -> 2*NBITS.
// One conditional addition of the shifted multiplicand per cycle, exactly
// NBITS iterations per operand pair, no early termination.
// istream_rdy / ostream_val are decoded from state only, so there is no
// combinational path between the two streams.
module multiplier_iterative_8b #(
   parameter  int NBITS = 8,
   localparam int CW    = $clog2(NBITS) + 1
) (
   input  logic                 clk,
   input  logic                 reset,      // asynchronous, active-low
   multiplier_iterative_8b_if.slave io,
   output logic [1:0]           state_dbg,  // current FSM state
   output logic [CW-1:0]        count_dbg   // current iteration counter
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Counter value during the final CALC iteration
   localparam logic [CW-1:0] LAST_ITER = CW'(NBITS - 1);

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [2*NBITS-1:0] a_reg;     // multiplicand, shifted left each iteration
   logic [NBITS-1:0]   b_reg;     // multiplier, shifted right each iteration
   logic [2*NBITS-1:0] acc;       // partial-product accumulator
   logic [2*NBITS-1:0] acc_sum;   // accumulator plus gated multiplicand
   logic [CW-1:0]      count;
   logic               in_xfer;
   logic               out_xfer;
   logic               last_iter;

   // Stream control decoded purely from state
   assign io.istream_rdy = (state == IDLE);
   assign io.ostream_val = (state == DONE);
   assign io.product     = acc;

   assign in_xfer   = io.istream_val & io.istream_rdy;
   assign out_xfer  = io.ostream_val & io.ostream_rdy;
   assign last_iter = (count == LAST_ITER);

   assign state_dbg = state;
   assign count_dbg = count;

   // Ripple adder: add the shifted multiplicand when the current multiplier bit is set;
   // the carry out of the MSB cannot be nonzero for NBITS-bit operands
   always_comb begin
      acc_sum = acc;
      if (b_reg[0]) begin
         acc_sum = acc + a_reg;
      end
   end

   // Next-state selection: accept -> NBITS iterations -> hold product until taken
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_xfer) begin
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_xfer) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath: load operands on acceptance, shift/accumulate while calculating,
   // otherwise hold so the product stays stable under backpressure
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_xfer) begin
                  a_reg <= {{NBITS{1'b0}}, io.in0};
                  b_reg <= io.in1;
                  acc   <= '0;
                  count <= '0;
               end
            end
            CALC: begin
               acc   <= acc_sum;
               a_reg <= a_reg << 1;
               b_reg <= b_reg >> 1;
               count <= count + 1'b1;
            end
            default: begin
               // DONE: everything holds until the product is taken
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_iterative_8b.sv
// Directed and random bench for multiplier_iterative_8b.
module tb_multiplier_iterative_8b;

   localparam int NBITS = 8;
   localparam int CW    = $clog2(NBITS) + 1;

   logic          clk;
   logic          reset;
   logic [1:0]    state_dbg;
   logic [CW-1:0] count_dbg;

   multiplier_iterative_8b_if #(.NBITS(NBITS)) io ();

   multiplier_iterative_8b #(.NBITS(NBITS)) dut (
      .clk       (clk),
      .reset     (reset),
      .io        (io),
      .state_dbg (state_dbg),
      .count_dbg (count_dbg)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard
   logic [2*NBITS-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver: one full transaction, entered and left at a negedge with the DUT idle.
   // stall = cycles of ostream_rdy=0 after product valid; poke = drive other
   // operands with istream_val=1 during CALC (must be ignored).
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                          input int stall, input bit poke, input string tag);
      int n;
      int bad_rdy;
      logic [2*NBITS-1:0] exp;
      io.in0         = a;
      io.in1         = b;
      io.istream_val = 1'b1;
      io.ostream_rdy = 1'b0;
      check({tag, "_in_rdy"}, 32'(io.istream_rdy), 32'd1);
      @(posedge clk);
      exp_q.push_back(16'(a) * 16'(b));
      @(negedge clk);
      io.istream_val = poke;
      io.in0 = poke ? 8'hFF : 8'($urandom);
      io.in1 = poke ? 8'hFF : 8'($urandom);
      n = 0;
      bad_rdy = 0;
      while (io.ostream_val !== 1'b1 && n < 40) begin
         if (io.istream_rdy !== 1'b0) bad_rdy++;
         @(negedge clk);
         n++;
         if (n == 4) io.istream_val = 1'b0;
         io.in0 = 8'($urandom);
         io.in1 = 8'($urandom);
      end
      io.istream_val = 1'b0;
      check({tag, "_latency"}, 32'(n), 32'(NBITS));
      check({tag, "_calc_rdy"}, 32'(bad_rdy), 32'd0);
      check({tag, "_count"}, 32'(count_dbg), 32'(NBITS));
      for (int i = 0; i < stall; i++) begin
         check({tag, "_stall_val"}, 32'(io.ostream_val), 32'd1);
         check({tag, "_stall_rdy"}, 32'(io.istream_rdy), 32'd0);
         check({tag, "_stall_prod"}, 32'(io.product), 32'(exp_q[0]));
         @(negedge clk);
      end
      io.ostream_rdy = 1'b1;
      check({tag, "_val"}, 32'(io.ostream_val), 32'd1);
      exp = exp_q.pop_front();
      check({tag, "_product"}, 32'(io.product), 32'(exp));
      @(posedge clk);
      @(negedge clk);
      io.ostream_rdy = 1'b0;
      check({tag, "_idle_val"}, 32'(io.ostream_val), 32'd0);
      check({tag, "_idle_rdy"}, 32'(io.istream_rdy), 32'd1);
   endtask

   // Watchdog: the main sequence is bounded, this guards against a stuck clock
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Directed sequence followed by random transactions
   initial begin
      logic [2*NBITS-1:0] dropped;
      reset          = 1'b0;
      io.istream_val = 1'b0;
      io.in0         = '0;
      io.in1         = '0;
      io.ostream_rdy = 1'b0;
      #1;
      check("rst_in_rdy", 32'(io.istream_rdy), 32'd1);
      check("rst_out_val", 32'(io.ostream_val), 32'd0);
      check("rst_product", 32'(io.product), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_in_rdy", 32'(io.istream_rdy), 32'd1);
      check("post_rst_out_val", 32'(io.ostream_val), 32'd0);
      check("post_rst_product", 32'(io.product), 32'd0);

      // Basic and boundary operands
      run_txn(8'd3,   8'd5,   0, 1'b0, "basic_3x5");
      run_txn(8'h00,  8'hAB,  0, 1'b0, "zero_a");
      run_txn(8'hAB,  8'h00,  0, 1'b0, "zero_b");
      run_txn(8'hFF,  8'hFF,  0, 1'b0, "max");
      run_txn(8'h80,  8'h02,  0, 1'b0, "msb_shift");
      run_txn(8'h01,  8'hFF,  0, 1'b0, "one_x_ff");

      // Backpressure on the product stream
      run_txn(8'd12,  8'd12,  5, 1'b0, "backpressure");

      // Operands offered during CALC must be ignored
      run_txn(8'd9,   8'd11,  1, 1'b1, "ignore_calc");

      // Back-to-back pairs
      run_txn(8'd7,   8'd9,   0, 1'b0, "b2b_first");
      run_txn(8'd200, 8'd100, 0, 1'b0, "b2b_second");

      // Asynchronous reset in the middle of CALC
      io.in0         = 8'd10;
      io.in1         = 8'd10;
      io.istream_val = 1'b1;
      @(posedge clk);
      exp_q.push_back(16'd100);
      @(negedge clk);
      io.istream_val = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_out_val", 32'(io.ostream_val), 32'd0);
      check("midrst_in_rdy", 32'(io.istream_rdy), 32'd1);
      check("midrst_product", 32'(io.product), 32'd0);
      check("midrst_state", 32'(state_dbg), 32'd0);
      dropped = exp_q.pop_back();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("after_rst_out_val", 32'(io.ostream_val), 32'd0);
      check("after_rst_in_rdy", 32'(io.istream_rdy), 32'd1);
      run_txn(8'd6,   8'd7,   0, 1'b0, "after_rst_6x7");

      // Random operands with random product stalls
      for (int i = 0; i < 50; i++) begin
         run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
      end

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      if (dropped != 16'd100) $display("[TB] note: discarded entry %0d", dropped);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
